femto_bram_responder: RTL

Memory-side responder for the FemtoRV32 data/instruction bus: answers the processor's read strobes and write masks from an internal block RAM. It drives mem_rbusy/mem_wbusy with a programmable number of wait states. It sits beside the SDRAM controller in the SoC address map and provides a fast, deterministic target for boot code and bus-timing verification. It decodes its own address window and stays silent outside it.

---
 rtl/femto_bram_responder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/femto_bram_responder.sv
// Block-RAM target for the FemtoRV32 memory bus with programmable read/write wait states.
// Optional sticky protocol-error flag enabled by defining BRAM_RESPONDER_ERR_EN.
module femto_bram_responder #(
    parameter int unsigned DEPTH_WORDS   = 1024,
    parameter logic [31:0] SEL_MASK      = 32'h00f0_0000,
    parameter logic [31:0] SEL_MATCH     = 32'h0000_0000,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        mem_wbusy,
    output logic        selected
`ifdef BRAM_RESPONDER_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] RD_CNT_INIT = (READ_LATENCY > 32'd0) ? 4'(READ_LATENCY - 32'd1) : 4'd0;
    localparam logic [3:0] WR_CNT_INIT = (WRITE_LATENCY > 32'd0) ? 4'(WRITE_LATENCY - 32'd1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wmask_q;
    logic [31:0]     rdata_q;
    logic            rbusy_q;
    logic            wbusy_q;
    logic [31:0]     mem_q [0:DEPTH_WORDS-1];

    logic            sel_s;
    logic            idle_s;
    logic            last_s;
    logic            wr_acc_s;
    logic            rd_acc_s;
    logic            wr_commit_s;
    logic [AW-1:0]   idx_d;
    logic [31:0]     wdata_d;
    logic [3:0]      wmask_d;
    logic [31:0]     rd_word_s;

    // Address decode, strobe acceptance and RAM port selection (live inputs in IDLE, latched ones otherwise).
    always_comb begin
        sel_s    = ((mem_addr & SEL_MASK) == SEL_MATCH);
        idle_s   = (state_q == S_IDLE);
        last_s   = (cnt_q == 4'd0);
        wr_acc_s = idle_s && sel_s && (mem_wmask != 4'd0);
        rd_acc_s = idle_s && sel_s && mem_rstrb && (mem_wmask == 4'd0);
        if (idle_s) begin
            idx_d   = mem_addr[AW+1:2];
            wdata_d = mem_wdata;
            wmask_d = mem_wmask;
        end else begin
            idx_d   = idx_q;
            wdata_d = wdata_q;
            wmask_d = wmask_q;
        end
        case (state_q)
            S_IDLE:    wr_commit_s = wr_acc_s && (WRITE_LATENCY == 32'd0);
            S_WR_WAIT: wr_commit_s = last_s;
            default:   wr_commit_s = 1'b0;
        endcase
        rd_word_s = mem_q[idx_d];
    end

    // Access sequencer: accepts strobes in IDLE, counts wait states, owns all registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wmask_q <= 4'd0;
            rdata_q <= 32'd0;
            rbusy_q <= 1'b0;
            wbusy_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wr_acc_s) begin
                        idx_q   <= mem_addr[AW+1:2];
                        wdata_q <= mem_wdata;
                        wmask_q <= mem_wmask;
                        if (WRITE_LATENCY != 32'd0) begin
                            state_q <= S_WR_WAIT;
                            cnt_q   <= WR_CNT_INIT;
                            wbusy_q <= 1'b1;
                        end
                    end else if (rd_acc_s) begin
                        idx_q <= mem_addr[AW+1:2];
                        if (READ_LATENCY == 32'd0) begin
                            rdata_q <= rd_word_s;
                        end else begin
                            state_q <= S_RD_WAIT;
                            cnt_q   <= RD_CNT_INIT;
                            rbusy_q <= 1'b1;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (last_s) begin
                        rdata_q <= rd_word_s;
                        rbusy_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_WR_WAIT: begin
                    if (last_s) begin
                        wbusy_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    rbusy_q <= 1'b0;
                    wbusy_q <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane RAM write; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_commit_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_d[b]) begin
                    mem_q[idx_d][8*b +: 8] <= wdata_d[8*b +: 8];
                end
            end
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_rbusy = rbusy_q;
    assign mem_wbusy = wbusy_q;
    assign selected  = sel_s;

`ifdef BRAM_RESPONDER_ERR_EN
    localparam logic [31:0] HI_MASK    = ~((32'd1 << (AW + 2)) - 32'd1);
    localparam logic [31:0] ALIAS_MASK = HI_MASK & ~SEL_MASK;

    logic err_set_s;
    logic err_q;

    // Protocol violations: busy-time strobe, read+write collision, aliased window hit.
    always_comb begin
        err_set_s = (sel_s && (mem_rstrb || (mem_wmask != 4'd0)) &&
                     (!idle_s || ((mem_addr & ALIAS_MASK) != 32'd0))) ||
                    (mem_rstrb && (mem_wmask != 4'd0));
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | err_set_s;
        end
    end

    assign err = err_q;
`endif

endmodule
